// File: rtl/cpu_bus_pkg.sv
// Shared types and widths for the CPU bus responder: FSM state, response payload, bus widths.
package cpu_bus_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned TXN_W  = 8;

  localparam logic [DATA_W-1:0] ERR_DATA_DEF = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WDATA  = 2'd1,
    ST_RDRIVE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  // Registered response presented to the initiator while ack is high.
  typedef struct packed {
    logic              ack;
    logic              err;
    logic [DATA_W-1:0] oe;
    logic [DATA_W-1:0] data;
  } resp_t;

endpackage

// File: rtl/cpu_bus_responder_if.sv
// Four-phase request/acknowledge bus between an initiator (master) and the responder (slave).
interface cpu_bus_responder_if;
  import cpu_bus_pkg::*;

  logic              ena;
  logic              req;
  logic              wr;
  logic [ADDR_W-1:0] bus_in;
  logic [DATA_W-1:0] bus_out;
  logic [DATA_W-1:0] bus_oe;
  logic              ack;
  logic              err;
  logic [TXN_W-1:0]  txn_count;

  modport master (
    output ena, req, wr, bus_in,
    input  bus_out, bus_oe, ack, err, txn_count
  );

  modport slave (
    input  ena, req, wr, bus_in,
    output bus_out, bus_oe, ack, err, txn_count
  );

endinterface

// File: rtl/cpu_bus_responder_mem.sv
// Byte storage for the responder: one synchronous write port, one combinational read port,
// cleared synchronously while reset is asserted.
module responder_mem
  import cpu_bus_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IDX_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Reset wins over a write issued on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    if (32'(raddr) < DEPTH) begin
      rdata = mem[raddr];
    end
  end

endmodule

// File: rtl/cpu_bus_responder.sv
// Four-phase CPU bus responder: accepts a read or write in IDLE, answers with ack two
// register stages later, holds the response until req drops, and counts completions.
module cpu_bus_responder
  import cpu_bus_pkg::*;
#(
  parameter int unsigned       MEM_DEPTH = 16,
  parameter logic [DATA_W-1:0] ERR_DATA  = ERR_DATA_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  cpu_bus_responder_if.slave  bus
);

  localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_nxt;
  resp_t             resp_q;
  resp_t             resp_nxt;
  logic [TXN_W-1:0]  txn_q;
  logic [TXN_W-1:0]  txn_nxt;

  logic              in_range_c;
  logic              we_c;
  logic [DATA_W-1:0] rdata_c;

  // Addresses at or beyond MEM_DEPTH are errors; with 16 bytes that is addr[7:4] != 0.
  assign in_range_c = (32'(addr_q) < MEM_DEPTH);

  responder_mem #(
    .DEPTH (MEM_DEPTH),
    .IDX_W (IDX_W)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we_c),
    .waddr (addr_q[IDX_W-1:0]),
    .wdata (bus.bus_in),
    .raddr (addr_q[IDX_W-1:0]),
    .rdata (rdata_c)
  );

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      addr_q <= '0;
      resp_q <= '0;
      txn_q  <= '0;
    end else begin
      state  <= state_nxt;
      addr_q <= addr_nxt;
      resp_q <= resp_nxt;
      txn_q  <= txn_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (bus.req && bus.ena) begin
          state_nxt = bus.wr ? ST_WDATA : ST_RDRIVE;
        end
      end
      ST_WDATA:  state_nxt = ST_HOLD;
      ST_RDRIVE: state_nxt = ST_HOLD;
      ST_HOLD: begin
        if (!bus.req) begin
          state_nxt = ST_IDLE;
        end
      end
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Output / datapath next values; everything holds unless a state acts on it.
  always_comb begin
    addr_nxt = addr_q;
    resp_nxt = resp_q;
    txn_nxt  = txn_q;
    we_c     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.req && bus.ena) begin
          addr_nxt = bus.bus_in;
        end
      end
      ST_WDATA: begin
        we_c          = in_range_c;
        resp_nxt.ack  = 1'b1;
        resp_nxt.err  = !in_range_c;
        resp_nxt.oe   = '0;
        resp_nxt.data = '0;
      end
      ST_RDRIVE: begin
        resp_nxt.ack  = 1'b1;
        resp_nxt.err  = !in_range_c;
        resp_nxt.oe   = {DATA_W{1'b1}};
        resp_nxt.data = in_range_c ? rdata_c : ERR_DATA;
      end
      ST_HOLD: begin
        if (!bus.req) begin
          resp_nxt = '0;
          txn_nxt  = txn_q + TXN_W'(1);
        end
      end
      default: begin
        resp_nxt = '0;
      end
    endcase
  end

  assign bus.ack       = resp_q.ack;
  assign bus.err       = resp_q.err;
  assign bus.bus_oe    = resp_q.oe;
  assign bus.bus_out   = resp_q.data;
  assign bus.txn_count = txn_q;

endmodule
